g1_inverse_scan: RTL and testbench

//   Inverse of the g1 gate network (y0 = !(x1 & x0 & !x2), y1 = !(x3 & x2)).

---
 rtl/g1_inverse_scan.sv | 135 +++++++++++++
 tb/tb_g1_inverse_scan.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/g1_inverse_scan.sv
// g1_inverse_scan: enumerates every 4-bit x with g1(x) == y_target over a valid/ready stream.
// Optional G1_INV_ABORT_EN adds an abort input that ends a scan early.
module g1_inverse_scan #(
  parameter int CNT_W    = 5,
  parameter bit SCAN_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       y_target,
  input  logic             x_ready,
`ifdef G1_INV_ABORT_EN
  input  logic             abort,
`endif
  output logic [3:0]       x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] FIRST = SCAN_DIR ? 4'd15 : 4'd0;
  localparam logic [3:0] LAST  = SCAN_DIR ? 4'd0 : 4'd15;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [3:0]       idx_d;
  logic [1:0]       y_q;
  logic [3:0]       x_out_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] g1_y;
  logic       hit;
  logic       at_last;
  logic       abort_w;

`ifdef G1_INV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // g1 evaluated on the scan index only, never on the outputs
  assign g1_y[0] = ~(idx_q[1] & idx_q[0] & ~idx_q[2]);
  assign g1_y[1] = ~(idx_q[3] & idx_q[2]);
  assign hit     = (g1_y == y_q);
  assign at_last = (idx_q == LAST);
  assign idx_d   = SCAN_DIR ? idx_q - 4'd1 : idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      y_q       <= 2'd0;
      x_out_q   <= 4'd0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            y_q     <= y_target;
            cnt_q   <= '0;
            idx_q   <= FIRST;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (hit) begin
            x_out_q   <= idx_q;
            x_valid_q <= 1'b1;
            state_q   <= HOLD;
          end else if (at_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        HOLD: begin
          if (abort_w) begin
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (x_ready) begin
            x_valid_q <= 1'b0;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (at_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_d;
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_g1_inverse_scan.sv
// Scoreboard bench for g1_inverse_scan: ascending and descending instances
// share stimulus; a negedge monitor pops expected x values per instance.
module tb_g1_inverse_scan;
  localparam int CW = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       x_ready = 1'b0;
  logic [1:0] y_target = 2'd0;
  logic       ab;
`ifdef G1_INV_ABORT_EN
  logic       abort = 1'b0;
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  logic [3:0]    xo[2];
  logic          xv[2];
  logic          bz[2];
  logic          dn[2];
  logic [CW-1:0] mc[2];

  always #5 clk = ~clk;

  g1_inverse_scan #(.CNT_W(CW), .SCAN_DIR(1'b0)) u_asc (
    .clk(clk), .rst(rst), .start(start), .y_target(y_target),
    .x_ready(x_ready),
`ifdef G1_INV_ABORT_EN
    .abort(abort),
`endif
    .x_out(xo[0]), .x_valid(xv[0]), .busy(bz[0]), .done(dn[0]),
    .match_count(mc[0])
  );

  g1_inverse_scan #(.CNT_W(CW), .SCAN_DIR(1'b1)) u_desc (
    .clk(clk), .rst(rst), .start(start), .y_target(y_target),
    .x_ready(x_ready),
`ifdef G1_INV_ABORT_EN
    .abort(abort),
`endif
    .x_out(xo[1]), .x_valid(xv[1]), .busy(bz[1]), .done(dn[1]),
    .match_count(mc[1])
  );

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int   expn[2];
  int   acc[2];
  int   first_k[2];
  bit   first[2];
  bit   fin[2];
  bit   pstall[2];
  logic [3:0] px[2];
  int   start_cyc = 0;
  bit   quiet = 1'b1;
  bit   aborted = 1'b0;

  // Reference: y1 is high unless x >= 12, y0 is high unless x mod 8 == 3
  function automatic bit g1_hit(int x, logic [1:0] y);
    bit y1;
    bit y0;
    y1 = (x < 12);
    y0 = ((x % 8) != 3);
    return ({y1, y0} == y);
  endfunction

  task automatic chk(bit ok, string nm, int act, int exp);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!quiet && !rst) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] e;
        int sz;
        int ecnt;
        if (pstall[d])
          chk(xv[d] === 1'b1 && xo[d] === px[d], "stall_hold",
              int'(xo[d]), int'(px[d]));
        pstall[d] = xv[d] && !x_ready && !ab;
        px[d] = xo[d];
        if (xv[d]) begin
          chk(bz[d] === 1'b1, "busy_in_hold", int'(bz[d]), 1);
          if (first[d]) begin
            first[d] = 1'b0;
            chk(cyc - start_cyc == 1 + first_k[d], "first_latency",
                cyc - start_cyc, 1 + first_k[d]);
          end
          if (x_ready && !ab) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
              chk(1'b0, "extra_x", int'(xo[d]), -1);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk(xo[d] === e, "x_out", int'(xo[d]), int'(e));
            end
            acc[d]++;
          end
        end
        if (dn[d] === 1'b1 && !fin[d]) begin
          fin[d] = 1'b1;
          ecnt = (acc[d] > 31) ? 31 : acc[d];
          chk(bz[d] === 1'b0, "done_busy", int'(bz[d]), 0);
          chk(int'(mc[d]) == ecnt, "match_count", int'(mc[d]), ecnt);
          if (!aborted) begin
            chk(acc[d] == expn[d], "match_total", acc[d], expn[d]);
            if (expn[d] == 0)
              chk(cyc - start_cyc == 16, "done_latency",
                  cyc - start_cyc, 16);
          end
        end
      end
    end
  end

  task automatic begin_scan(logic [1:0] y, bit rdy);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 16; i++) if (g1_hit(i, y)) q0.push_back(4'(i));
    for (int i = 15; i >= 0; i--) if (g1_hit(i, y)) q1.push_back(4'(i));
    for (int d = 0; d < 2; d++) begin
      expn[d] = (d == 0) ? q0.size() : q1.size();
      acc[d] = 0;
      first[d] = 1'b1;
      fin[d] = 1'b0;
      pstall[d] = 1'b0;
    end
    first_k[0] = (q0.size() > 0) ? int'(q0[0]) : 0;
    first_k[1] = (q1.size() > 0) ? 15 - int'(q1[0]) : 0;
    aborted = 1'b0;
    quiet = 1'b0;
    x_ready = rdy;
    y_target = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    y_target = 2'($urandom);
  endtask

  // mode 0: ready high, 1: random, 2: low three cycles out of four
  task automatic run_scan(logic [1:0] y, int mode, bit extra_start);
    bit ok;
    ok = 1'b0;
    begin_scan(y, mode == 0);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (fin[0] && fin[1]) begin
        ok = 1'b1;
        break;
      end
      case (mode)
        0: x_ready = 1'b1;
        1: x_ready = ($urandom_range(99) < 50);
        default: x_ready = ((c % 4) == 3);
      endcase
      if (extra_start && c == 3) begin
        y_target = ~y;
        start = 1'b1;
      end
    end
    if (!ok) chk(1'b0, "scan_timeout", 0, 1);
    x_ready = 1'b0;
  endtask

  initial begin
    int nd;
    bit seen;
    start = 1'b1;
    y_target = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk(xo[d] == 0 && xv[d] == 0 && bz[d] == 0 && dn[d] == 0 && mc[d] == 0,
          "reset_state", int'({xo[d], xv[d], bz[d], dn[d]}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk(bz[0] == 0 && bz[1] == 0, "idle_after_reset",
        int'({bz[0], bz[1]}), 0);
    @(posedge clk);
    #1;

    run_scan(2'b10, 0, 1'b0);
    run_scan(2'b01, 2, 1'b0);
    run_scan(2'b00, 1, 1'b0);
    run_scan(2'b11, 0, 1'b1);
    for (int r = 0; r < 8; r++) run_scan(2'($urandom), 1, r[0]);

    // reset while holding a stalled match
    begin_scan(2'b01, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (xv[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "hold_reached", int'(seen), 1);
    @(posedge clk);
    #1;
    quiet = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk(xv[d] == 0 && bz[d] == 0 && dn[d] == 0 && mc[d] == 0,
          "mid_reset", int'({xv[d], bz[d], dn[d]}), 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (dn[0] || dn[1]) nd++;
    end
    chk(nd == 0, "no_done_after_reset", nd, 0);
    @(posedge clk);
    #1;

`ifdef G1_INV_ABORT_EN
    begin_scan(2'b01, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (xv[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "abort_hold_reached", int'(seen), 1);
    @(posedge clk);
    #1;
    aborted = 1'b1;
    abort = 1'b1;
    x_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    x_ready = 1'b0;
    @(negedge clk);
    chk(dn[0] === 1'b1 && dn[1] === 1'b1, "abort_done",
        int'({dn[0], dn[1]}), 3);
    chk(xv[0] === 1'b0 && xv[1] === 1'b0, "abort_drop_valid",
        int'({xv[0], xv[1]}), 0);
    @(posedge clk);
    #1;
    quiet = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
